// File: rtl/spi_reg_decoder.sv
// SPI register-file decoder: turns the byte stream of an SPI slave receiver
// into auto-incrementing reads and writes of a small 8-bit register file and
// supplies the next byte to be shifted back out.
module spi_reg_decoder #(
    parameter int         NREGS    = 16,
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               frame_end,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic [7:0]         tx_data,
    output logic               led,
    output logic [8*NREGS-1:0] regs_flat,
    output logic               busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RD   = 2'd3;

    logic [1:0] state;
    logic [1:0] state_n;
    logic [6:0] addr;
    logic [6:0] addr_n;
    logic [7:0] tx_n;
    logic [7:0] frame_cnt;
    logic [7:0] frame_cnt_n;
    logic [7:0] err_cnt;
    logic [7:0] err_cnt_n;
    logic       wr_en;

    // Backing store for the writable registers (ctrl and scratch). Slots 0, 2
    // and 3 exist only to keep indexing uniform; their visible values come
    // from the ID constant and the two counters instead.
    logic [7:0] mem [NREGS];

    function automatic logic in_range(input logic [6:0] a);
        return int'({25'd0, a}) < NREGS;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Out-of-range addresses fall through the loop and read as zero.
    function automatic logic [7:0] rdata(input logic [6:0] a,
                                         input logic [8*NREGS-1:0] flat);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < NREGS; i++) begin
            if (a == i[6:0]) r = flat[8*i +: 8];
        end
        return r;
    endfunction

    // Assemble the externally visible register map.
    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (i == 0)      regs_flat[8*i +: 8] = ID_VALUE;
            else if (i == 2) regs_flat[8*i +: 8] = frame_cnt;
            else if (i == 3) regs_flat[8*i +: 8] = err_cnt;
            else             regs_flat[8*i +: 8] = mem[i];
        end
    end

    assign led  = mem[1][0];
    assign busy = (state != IDLE);

    // Next-state decode. frame_start overrides everything else in its cycle;
    // otherwise a received byte is processed first and frame_end then closes
    // the frame, so a last byte arriving with frame_end still takes effect.
    always_comb begin
        state_n     = state;
        addr_n      = addr;
        tx_n        = tx_data;
        frame_cnt_n = frame_cnt;
        err_cnt_n   = err_cnt;
        wr_en       = 1'b0;
        if (frame_start) begin
            state_n     = CMD;
            frame_cnt_n = frame_cnt + 8'd1;
            tx_n        = frame_cnt;
            if (state != IDLE) err_cnt_n = sat_inc(err_cnt);
        end else begin
            if (rx_valid) begin
                case (state)
                    CMD: begin
                        if (rx_data[7]) begin
                            // Header read: first data byte is ready one edge later.
                            state_n = RD;
                            tx_n    = rdata(rx_data[6:0], regs_flat);
                            addr_n  = rx_data[6:0] + 7'd1;
                            if (!in_range(rx_data[6:0])) err_cnt_n = sat_inc(err_cnt);
                        end else begin
                            state_n = WR;
                            addr_n  = rx_data[6:0];
                            tx_n    = 8'h00;
                        end
                    end
                    WR: begin
                        wr_en  = in_range(addr);
                        addr_n = addr + 7'd1;
                        tx_n   = 8'h00;
                        if (!in_range(addr)) err_cnt_n = sat_inc(err_cnt);
                    end
                    RD: begin
                        tx_n   = rdata(addr, regs_flat);
                        addr_n = addr + 7'd1;
                        if (!in_range(addr)) err_cnt_n = sat_inc(err_cnt);
                    end
                    default: ;
                endcase
            end
            if (frame_end) begin
                state_n = IDLE;
                tx_n    = 8'h00;
            end
        end
    end

    // Control and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= 7'd0;
            tx_data   <= 8'h00;
            frame_cnt <= 8'h00;
            err_cnt   <= 8'h00;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            tx_data   <= tx_n;
            frame_cnt <= frame_cnt_n;
            err_cnt   <= err_cnt_n;
        end
    end

    // Register file writes; read-only slots silently ignore writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= 8'h00;
        end else if (wr_en) begin
            for (int i = 0; i < NREGS; i++) begin
                if (addr == i[6:0] && (i == 1 || i >= 4)) mem[i] <= rx_data;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_decoder.sv
// Self-checking bench for spi_reg_decoder: directed scenarios plus a
// randomized run compared against a frame-level behavioural model.
module tb_spi_reg_decoder;

    localparam int         N  = 16;
    localparam logic [7:0] ID = 8'hA5;

    logic           clk;
    logic           rst_n;
    logic           frame_start;
    logic           frame_end;
    logic           rx_valid;
    logic [7:0]     rx_data;
    logic [7:0]     tx_data;
    logic           led;
    logic [8*N-1:0] regs_flat;
    logic           busy;

    int checks;
    int failures;

    spi_reg_decoder #(.NREGS(N), .ID_VALUE(ID)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_data     (tx_data),
        .led         (led),
        .regs_flat   (regs_flat),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    bit         m_in_frame;
    bit         m_hdr_seen;
    bit         m_read;
    int         m_addr;
    logic [7:0] m_mem [N];
    logic [7:0] m_fc;
    logic [7:0] m_ec;
    logic [7:0] m_tx;

    function automatic logic [7:0] m_rdata(input int a);
        if (a >= N)  return 8'h00;
        if (a == 0)  return ID;
        if (a == 2)  return m_fc;
        if (a == 3)  return m_ec;
        return m_mem[a];
    endfunction

    function automatic logic [8*N-1:0] m_flat();
        logic [8*N-1:0] f;
        for (int i = 0; i < N; i++) f[8*i +: 8] = m_rdata(i);
        return f;
    endfunction

    function automatic logic [7:0] m_err_bump(input logic [7:0] e);
        return (e == 8'hFF) ? 8'hFF : e + 8'd1;
    endfunction

    task automatic model_reset();
        m_in_frame = 0;
        m_hdr_seen = 0;
        m_read     = 0;
        m_addr     = 0;
        m_fc       = 8'h00;
        m_ec       = 8'h00;
        m_tx       = 8'h00;
        for (int i = 0; i < N; i++) m_mem[i] = 8'h00;
    endtask

    task automatic model_access();
        if (m_read) begin
            m_tx = m_rdata(m_addr);
        end else begin
            if (m_addr < N && (m_addr == 1 || m_addr >= 4)) m_mem[m_addr] = rx_data;
            m_tx = 8'h00;
        end
        if (m_addr >= N) m_ec = m_err_bump(m_ec);
        m_addr = (m_addr + 1) % 128;
    endtask

    task automatic model_step(input bit fs, input bit fe, input bit rv, input logic [7:0] d);
        if (fs) begin
            if (m_in_frame) m_ec = m_err_bump(m_ec);
            m_tx       = m_fc;
            m_fc       = m_fc + 8'd1;
            m_in_frame = 1;
            m_hdr_seen = 0;
            return;
        end
        if (rv && m_in_frame) begin
            if (!m_hdr_seen) begin
                m_hdr_seen = 1;
                m_read     = d[7];
                m_addr     = int'(d[6:0]);
                if (m_read) model_access();
                else        m_tx = 8'h00;
            end else begin
                model_access();
            end
        end
        if (fe) begin
            m_in_frame = 0;
            m_tx       = 8'h00;
        end
    endtask

    // One clock: inputs driven at negedge, model advanced at posedge,
    // outputs sampled 1 time unit after the edge.
    task automatic step(input bit fs, input bit fe, input bit rv, input logic [7:0] d);
        @(negedge clk);
        frame_start = fs;
        frame_end   = fe;
        rx_valid    = rv;
        rx_data     = d;
        @(posedge clk);
        model_step(fs, fe, rv, d);
        #1;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [8*N-1:0] exp;
        exp      = '0;
        exp[7:0] = ID;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx actual=%h expected=00", tx_data); end
        checks++;
        if (busy !== 1'b0 || led !== 1'b0) begin failures++; $display("FAIL reset_busy_led actual=%b%b expected=00", busy, led); end
        checks++;
        if (regs_flat !== exp) begin failures++; $display("FAIL reset_regs actual=%h expected=%h", regs_flat, exp); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read_id();
        do_reset();
        step(1, 0, 0, 8'h00);
        checks++;
        if (busy !== 1'b1 || tx_data !== 8'h00) begin failures++; $display("FAIL id_start actual=%b/%h expected=1/00", busy, tx_data); end
        step(0, 0, 1, 8'h80);
        checks++;
        if (tx_data !== 8'hA5) begin failures++; $display("FAIL id_read actual=%h expected=a5", tx_data); end
        step(0, 0, 1, 8'h00);
        checks++;
        if (tx_data !== 8'h00) begin failures++; $display("FAIL id_reg1 actual=%h expected=00", tx_data); end
        step(0, 1, 0, 8'h00);
        checks++;
        if (tx_data !== 8'h00 || busy !== 1'b0) begin failures++; $display("FAIL id_end actual=%h/%b expected=00/0", tx_data, busy); end
    endtask

    task automatic test_led_write();
        do_reset();
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h01);
        step(0, 0, 1, 8'h01);
        step(0, 0, 1, 8'h3C);
        step(0, 1, 0, 8'h00);
        checks++;
        if (led !== 1'b1 || regs_flat[15:8] !== 8'h01) begin failures++; $display("FAIL led_write actual=%b/%h expected=1/01", led, regs_flat[15:8]); end
        checks++;
        if (regs_flat[23:16] !== 8'h01 || regs_flat[31:24] !== 8'h00) begin
            failures++; $display("FAIL led_ro_regs actual=%h/%h expected=01/00", regs_flat[23:16], regs_flat[31:24]);
        end
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h82);
        checks++;
        if (tx_data !== 8'h02) begin failures++; $display("FAIL led_fc_read actual=%h expected=02", tx_data); end
        step(0, 1, 0, 8'h00);
    endtask

    task automatic test_frame_counter();
        do_reset();
        step(1, 0, 0, 8'h00); step(0, 1, 0, 8'h00);
        step(1, 0, 0, 8'h00); step(0, 1, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        checks++;
        if (tx_data !== 8'h02) begin failures++; $display("FAIL fc_third_start actual=%h expected=02", tx_data); end
        step(0, 1, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h82);
        checks++;
        if (tx_data !== 8'h04) begin failures++; $display("FAIL fc_fourth_read actual=%h expected=04", tx_data); end
        step(0, 1, 0, 8'h00);
    endtask

    task automatic test_out_of_range();
        do_reset();
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h0F);
        step(0, 0, 1, 8'hAA);
        step(0, 0, 1, 8'hBB);
        step(0, 1, 0, 8'h00);
        checks++;
        if (regs_flat[127:120] !== 8'hAA || regs_flat[31:24] !== 8'h01) begin
            failures++; $display("FAIL oor_write actual=%h/%h expected=aa/01", regs_flat[127:120], regs_flat[31:24]);
        end
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'hFF);
        checks++;
        if (tx_data !== 8'h00 || regs_flat[31:24] !== 8'h02) begin
            failures++; $display("FAIL oor_read actual=%h/%h expected=00/02", tx_data, regs_flat[31:24]);
        end
        step(0, 0, 1, 8'h00);
        checks++;
        if (tx_data !== 8'hA5) begin failures++; $display("FAIL oor_wrap actual=%h expected=a5", tx_data); end
        step(0, 1, 0, 8'h00);
    endtask

    task automatic test_simultaneous();
        do_reset();
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h04);
        step(0, 1, 1, 8'h55);
        checks++;
        if (regs_flat[39:32] !== 8'h55 || busy !== 1'b0 || tx_data !== 8'h00) begin
            failures++; $display("FAIL sim_last_byte actual=%h/%b/%h expected=55/0/00", regs_flat[39:32], busy, tx_data);
        end
        step(0, 0, 1, 8'h81);
        checks++;
        if (busy !== 1'b0 || regs_flat[31:24] !== 8'h00) begin failures++; $display("FAIL sim_idle_rx actual=%b/%h expected=0/00", busy, regs_flat[31:24]); end
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h84);
        checks++;
        if (tx_data !== 8'h55) begin failures++; $display("FAIL sim_read4 actual=%h expected=55", tx_data); end
        step(1, 0, 0, 8'h00);
        checks++;
        if (busy !== 1'b1 || tx_data !== 8'h02 || regs_flat[31:24] !== 8'h01) begin
            failures++; $display("FAIL sim_restart actual=%b/%h/%h expected=1/02/01", busy, tx_data, regs_flat[31:24]);
        end
        step(1, 1, 0, 8'h00);
        checks++;
        if (busy !== 1'b1 || tx_data !== 8'h03 || regs_flat[31:24] !== 8'h02) begin
            failures++; $display("FAIL sim_start_end actual=%b/%h/%h expected=1/03/02", busy, tx_data, regs_flat[31:24]);
        end
        step(0, 1, 0, 8'h00);
    endtask

    task automatic test_reset_midframe();
        logic [8*N-1:0] exp;
        exp      = '0;
        exp[7:0] = ID;
        do_reset();
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h01);
        step(0, 0, 1, 8'h01);
        step(0, 0, 1, 8'h77);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (regs_flat !== exp || led !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL midreset actual=%h/%b/%b expected=%h/0/0", regs_flat, led, busy, exp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 1, 8'h05);
        step(0, 0, 1, 8'h33);
        checks++;
        if (regs_flat !== exp || busy !== 1'b0 || tx_data !== 8'h00) begin
            failures++; $display("FAIL midreset_rx actual=%h/%b/%h expected=%h/0/00", regs_flat, busy, tx_data, exp);
        end
    endtask

    task automatic test_random();
        bit         fs;
        bit         fe;
        bit         rv;
        logic [7:0] d;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            fs = ($urandom_range(0, 19) == 0);
            fe = ($urandom_range(0, 14) == 0);
            rv = ($urandom_range(0, 2) == 0);
            d  = 8'($urandom);
            if ($urandom_range(0, 3) != 0) d[6:0] = 7'($urandom_range(0, 20));
            step(fs, fe, rv, d);
            checks++;
            if (tx_data !== m_tx || busy !== m_in_frame || led !== m_mem[1][0] || regs_flat !== m_flat()) begin
                failures++;
                $display("FAIL random_cycle%0d actual tx=%h busy=%b led=%b regs=%h expected tx=%h busy=%b led=%b regs=%h",
                         n, tx_data, busy, led, regs_flat, m_tx, m_in_frame, m_mem[1][0], m_flat());
            end
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b1;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        model_reset();
        test_reset();
        test_read_id();
        test_led_write();
        test_frame_counter();
        test_out_of_range();
        test_simultaneous();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
